// File: rtl/alu_cmd_issuer_if.sv
// alu_cmd_issuer_if: bundles the command, ALU-drive and response channels of
// the ALU command issuer.
//   cmd_*  : command channel (valid/ready) from the control sequencer
//   alu_*  : operands/select to, and result/carry from, the combinational ALU
//   rsp_*  : response channel (valid/ready) back to the consumer
//   rsp_zero exists only when ALU_ISSUER_ZERO_FLAG_EN is defined.
// Modports: slave = issuer view, master = sequencer/ALU/consumer view.
interface alu_cmd_issuer_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned REP_W = 2
) ();
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic             cmd_load;
    logic [REP_W-1:0] cmd_rep;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_sel;
    logic [WIDTH-1:0] alu_result;
    logic             alu_carry;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_carry;
`ifdef ALU_ISSUER_ZERO_FLAG_EN
    logic             rsp_zero;
`endif

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_load, cmd_rep,
        output cmd_ready,
        output alu_a, alu_b, alu_sel,
        input  alu_result, alu_carry,
        output rsp_valid, rsp_result, rsp_carry,
`ifdef ALU_ISSUER_ZERO_FLAG_EN
        output rsp_zero,
`endif
        input  rsp_ready
    );

    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_load, cmd_rep,
        input  cmd_ready,
        input  alu_a, alu_b, alu_sel,
        output alu_result, alu_carry,
        input  rsp_valid, rsp_result, rsp_carry,
`ifdef ALU_ISSUER_ZERO_FLAG_EN
        input  rsp_zero,
`endif
        output rsp_ready
    );
endinterface

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: accepts ALU opcode commands, iterates the ALU 1..2^REP_W
// times with the result chained back into A (B held constant), and returns
// the final accumulator plus a sticky carry on the response channel.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - alu_cmd_issuer_if.slave (cmd_*, alu_*, rsp_* channels)
// Optional feature: define ALU_ISSUER_ZERO_FLAG_EN to add rsp_zero
// (1 when the final accumulator is zero), registered alongside rsp_result.
module alu_cmd_issuer #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned REP_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    alu_cmd_issuer_if.slave bus
);
    localparam int unsigned SEL_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e             state_q,        state_d;
    logic               primed_q,       primed_d;
    logic [WIDTH-1:0]   acc_q,          acc_d;
    logic [WIDTH-1:0]   a_reg_q,        a_reg_d;
    logic [WIDTH-1:0]   b_reg_q,        b_reg_d;
    logic [SEL_W-1:0]   op_reg_q,       op_reg_d;
    logic [REP_W-1:0]   rep_cnt_q,      rep_cnt_d;
    logic               carry_sticky_q, carry_sticky_d;
    logic [WIDTH-1:0]   alu_a_q,        alu_a_d;
    logic [WIDTH-1:0]   alu_b_q,        alu_b_d;
    logic [SEL_W-1:0]   alu_sel_q,      alu_sel_d;
    logic               cmd_ready_q,    cmd_ready_d;
    logic               rsp_valid_q,    rsp_valid_d;
    logic [WIDTH-1:0]   rsp_result_q,   rsp_result_d;
    logic               rsp_carry_q,    rsp_carry_d;
`ifdef ALU_ISSUER_ZERO_FLAG_EN
    logic               rsp_zero_q,     rsp_zero_d;
`endif

    // Next-state and datapath. The first EXEC cycle loads the ALU drive
    // registers; every following EXEC cycle is one ALU iteration.
    always_comb begin
        state_d        = state_q;
        primed_d       = primed_q;
        acc_d          = acc_q;
        a_reg_d        = a_reg_q;
        b_reg_d        = b_reg_q;
        op_reg_d       = op_reg_q;
        rep_cnt_d      = rep_cnt_q;
        carry_sticky_d = carry_sticky_q;
        alu_a_d        = alu_a_q;
        alu_b_d        = alu_b_q;
        alu_sel_d      = alu_sel_q;
        rsp_result_d   = rsp_result_q;
        rsp_carry_d    = rsp_carry_q;
`ifdef ALU_ISSUER_ZERO_FLAG_EN
        rsp_zero_d     = rsp_zero_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    op_reg_d       = bus.cmd_op;
                    b_reg_d        = bus.cmd_data;
                    rep_cnt_d      = bus.cmd_rep;
                    a_reg_d        = bus.cmd_load ? bus.cmd_data : acc_q;
                    carry_sticky_d = 1'b0;
                    primed_d       = 1'b0;
                    state_d        = EXEC;
                end
            end
            EXEC: begin
                if (!primed_q) begin
                    alu_a_d   = a_reg_q;
                    alu_b_d   = b_reg_q;
                    alu_sel_d = op_reg_q;
                    primed_d  = 1'b1;
                end else begin
                    acc_d          = bus.alu_result;
                    a_reg_d        = bus.alu_result;
                    carry_sticky_d = carry_sticky_q | bus.alu_carry;
                    if (rep_cnt_q == '0) begin
                        // Last iteration: ALU drive holds, response is captured.
                        state_d      = RESP;
                        rsp_result_d = bus.alu_result;
                        rsp_carry_d  = carry_sticky_q | bus.alu_carry;
`ifdef ALU_ISSUER_ZERO_FLAG_EN
                        rsp_zero_d   = (bus.alu_result == '0);
`endif
                    end else begin
                        rep_cnt_d = rep_cnt_q - REP_W'(1);
                        alu_a_d   = bus.alu_result;
                    end
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cmd_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            primed_q       <= 1'b0;
            acc_q          <= '0;
            a_reg_q        <= '0;
            b_reg_q        <= '0;
            op_reg_q       <= '0;
            rep_cnt_q      <= '0;
            carry_sticky_q <= 1'b0;
            alu_a_q        <= '0;
            alu_b_q        <= '0;
            alu_sel_q      <= '0;
            cmd_ready_q    <= 1'b1;
            rsp_valid_q    <= 1'b0;
            rsp_result_q   <= '0;
            rsp_carry_q    <= 1'b0;
`ifdef ALU_ISSUER_ZERO_FLAG_EN
            rsp_zero_q     <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            primed_q       <= primed_d;
            acc_q          <= acc_d;
            a_reg_q        <= a_reg_d;
            b_reg_q        <= b_reg_d;
            op_reg_q       <= op_reg_d;
            rep_cnt_q      <= rep_cnt_d;
            carry_sticky_q <= carry_sticky_d;
            alu_a_q        <= alu_a_d;
            alu_b_q        <= alu_b_d;
            alu_sel_q      <= alu_sel_d;
            cmd_ready_q    <= cmd_ready_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_result_q   <= rsp_result_d;
            rsp_carry_q    <= rsp_carry_d;
`ifdef ALU_ISSUER_ZERO_FLAG_EN
            rsp_zero_q     <= rsp_zero_d;
`endif
        end
    end

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_sel    = alu_sel_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_carry  = rsp_carry_q;
`ifdef ALU_ISSUER_ZERO_FLAG_EN
    assign bus.rsp_zero   = rsp_zero_q;
`endif

endmodule
